// File: rtl/gba_cart_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// gba_cart_responder_if : cart bus + external ROM port bundle
// Revision 1.0 - initial release
// ============================================================================
interface gba_cart_responder_if #(
  parameter int ROM_ADDR_BITS = 25
);
  logic [31:0]              cart_addr;
  logic                     cart_rd;
  logic                     cart_wr;
  logic [31:0]              cart_wdata;
  logic [31:0]              cart_rdata;
  logic                     cpu_pause;
  logic [ROM_ADDR_BITS-1:0] rom_addr;
  logic                     rom_req;
  logic                     rom_ack;
  logic [31:0]              rom_rdata;

  modport master (
    output cart_addr, cart_rd, cart_wr, cart_wdata, rom_ack, rom_rdata,
    input  cart_rdata, cpu_pause, rom_addr, rom_req
  );

  modport slave (
    input  cart_addr, cart_rd, cart_wr, cart_wdata, rom_ack, rom_rdata,
    output cart_rdata, cpu_pause, rom_addr, rom_req
  );
endinterface
`default_nettype wire

// File: rtl/gba_cart_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// gba_cart_responder : GBA cart-side ROM/SRAM responder with prefetch
// Revision 1.0 - initial release
// ============================================================================
module gba_cart_responder #(
  parameter int ROM_ADDR_BITS  = 25,
  parameter int SRAM_ADDR_BITS = 16,
  parameter bit PREFETCH_EN    = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  gba_cart_responder_if.slave  bus
);
  localparam int c_TAG_W = ROM_ADDR_BITS - 2;
  localparam logic [c_TAG_W-1:0] c_TAG_ONE = {{(c_TAG_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH    = 2'd1,
    S_PREFETCH = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [31:0]          r_rdata, w_rdata_nxt;
  logic                 r_sram_sel, w_sel_nxt;
  logic                 r_pause, w_pause_nxt;
  logic                 r_req, w_req_nxt;
  logic [c_TAG_W-1:0]   r_tag, w_tag_nxt;
  logic                 r_dv, w_dv_nxt;
  logic [c_TAG_W-1:0]   r_dtag, w_dtag_nxt;
  logic [31:0]          r_ddata, w_ddata_nxt;
  logic                 r_pv, w_pv_nxt;
  logic [c_TAG_W-1:0]   r_ptag, w_ptag_nxt;
  logic [31:0]          r_pdata, w_pdata_nxt;
  logic                 r_pend, w_pend_nxt;
  logic                 r_pend_match, w_pmatch_nxt;
  logic [c_TAG_W-1:0]   r_pend_tag, w_pend_tag_nxt;
  logic [7:0]           r_sram [0:(1<<SRAM_ADDR_BITS)-1];
  logic [7:0]           r_sram_q;

  logic [7:0]                w_page;
  logic                      w_is_rom, w_is_sram, w_accept, w_rd;
  logic                      w_sram_we, w_sram_re, w_rom_rd, w_ack;
  logic                      w_dhit, w_phit;
  logic [c_TAG_W-1:0]        w_tag;
  logic [SRAM_ADDR_BITS-1:0] w_saddr;
  logic                      w_unused;

  assign w_page    = bus.cart_addr[31:24];
  assign w_is_rom  = (w_page >= 8'h08) && (w_page <= 8'h0D);
  assign w_is_sram = (w_page[7:1] == 7'h07);
  // Strobes seen while stalled are dropped; a write shadows a same-cycle read.
  assign w_accept  = !r_pause;
  assign w_rd      = bus.cart_rd && !bus.cart_wr && w_accept;
  assign w_sram_we = bus.cart_wr && w_accept && w_is_sram;
  assign w_sram_re = w_rd && w_is_sram;
  assign w_rom_rd  = w_rd && w_is_rom;
  assign w_tag     = bus.cart_addr[ROM_ADDR_BITS-1:2];
  assign w_saddr   = bus.cart_addr[SRAM_ADDR_BITS-1:0];
  assign w_ack     = bus.rom_ack && r_req;
  assign w_dhit    = r_dv && (r_dtag == w_tag);
  assign w_phit    = r_pv && (r_ptag == w_tag);
  assign w_unused  = &{1'b0, bus.cart_addr, bus.cart_wdata};

  assign bus.cart_rdata = r_sram_sel ? {4{r_sram_q}} : r_rdata;
  assign bus.cpu_pause  = r_pause;
  assign bus.rom_req    = r_req;
  assign bus.rom_addr   = {r_tag, 2'b00};

  always_ff @(posedge clock) begin
    if (w_sram_we) r_sram[w_saddr] <= bus.cart_wdata[7:0];
    if (w_sram_re) r_sram_q <= r_sram[w_saddr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rdata      <= 32'd0;
      r_sram_sel   <= 1'b0;
      r_pause      <= 1'b0;
      r_req        <= 1'b0;
      r_tag        <= '0;
      r_dv         <= 1'b0;
      r_dtag       <= '0;
      r_ddata      <= 32'd0;
      r_pv         <= 1'b0;
      r_ptag       <= '0;
      r_pdata      <= 32'd0;
      r_pend       <= 1'b0;
      r_pend_match <= 1'b0;
      r_pend_tag   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rdata      <= w_rdata_nxt;
      r_sram_sel   <= w_sel_nxt;
      r_pause      <= w_pause_nxt;
      r_req        <= w_req_nxt;
      r_tag        <= w_tag_nxt;
      r_dv         <= w_dv_nxt;
      r_dtag       <= w_dtag_nxt;
      r_ddata      <= w_ddata_nxt;
      r_pv         <= w_pv_nxt;
      r_ptag       <= w_ptag_nxt;
      r_pdata      <= w_pdata_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_match <= w_pmatch_nxt;
      r_pend_tag   <= w_pend_tag_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rdata_nxt    = r_rdata;
    w_sel_nxt      = r_sram_sel;
    w_pause_nxt    = r_pause;
    w_req_nxt      = r_req;
    w_tag_nxt      = r_tag;
    w_dv_nxt       = r_dv;
    w_dtag_nxt     = r_dtag;
    w_ddata_nxt    = r_ddata;
    w_pv_nxt       = r_pv;
    w_ptag_nxt     = r_ptag;
    w_pdata_nxt    = r_pdata;
    w_pend_nxt     = r_pend;
    w_pmatch_nxt   = r_pend_match;
    w_pend_tag_nxt = r_pend_tag;

    if (w_sram_re) w_sel_nxt = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_rom_rd) begin
          if (w_dhit) begin
            w_rdata_nxt = r_ddata;
            w_sel_nxt   = 1'b0;
          end else if (w_phit) begin
            w_rdata_nxt = r_pdata;
            w_sel_nxt   = 1'b0;
            if (PREFETCH_EN) begin
              w_state_nxt = S_PREFETCH;
              w_req_nxt   = 1'b1;
              w_tag_nxt   = r_ptag + c_TAG_ONE;
            end
          end else begin
            w_state_nxt = S_FETCH;
            w_req_nxt   = 1'b1;
            w_tag_nxt   = w_tag;
            w_pause_nxt = 1'b1;
          end
        end
      end

      S_FETCH: begin
        if (w_ack) begin
          w_rdata_nxt = bus.rom_rdata;
          w_sel_nxt   = 1'b0;
          w_dv_nxt    = 1'b1;
          w_dtag_nxt  = r_tag;
          w_ddata_nxt = bus.rom_rdata;
          w_pause_nxt = 1'b0;
          if (PREFETCH_EN) begin
            w_state_nxt = S_PREFETCH;
            w_tag_nxt   = r_tag + c_TAG_ONE;
            w_pv_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_req_nxt   = 1'b0;
          end
        end
      end

      S_PREFETCH: begin
        // The prefetch fill is always kept, even when a demand miss redirects us.
        if (w_ack) begin
          w_pv_nxt    = 1'b1;
          w_ptag_nxt  = r_tag;
          w_pdata_nxt = bus.rom_rdata;
          w_state_nxt = S_IDLE;
          w_req_nxt   = 1'b0;
        end
        if (r_pend) begin
          if (w_ack) begin
            w_pend_nxt = 1'b0;
            if (r_pend_match) begin
              w_rdata_nxt = bus.rom_rdata;
              w_sel_nxt   = 1'b0;
              w_pause_nxt = 1'b0;
            end else begin
              w_state_nxt = S_FETCH;
              w_req_nxt   = 1'b1;
              w_tag_nxt   = r_pend_tag;
            end
          end
        end else if (w_rom_rd) begin
          if (w_dhit) begin
            w_rdata_nxt = r_ddata;
            w_sel_nxt   = 1'b0;
          end else if (w_phit) begin
            w_rdata_nxt = r_pdata;
            w_sel_nxt   = 1'b0;
          end else if (w_tag == r_tag) begin
            if (w_ack) begin
              w_rdata_nxt = bus.rom_rdata;
              w_sel_nxt   = 1'b0;
            end else begin
              w_pend_nxt   = 1'b1;
              w_pmatch_nxt = 1'b1;
              w_pause_nxt  = 1'b1;
            end
          end else if (w_ack) begin
            w_state_nxt = S_FETCH;
            w_req_nxt   = 1'b1;
            w_tag_nxt   = w_tag;
            w_pause_nxt = 1'b1;
          end else begin
            w_pend_nxt     = 1'b1;
            w_pmatch_nxt   = 1'b0;
            w_pend_tag_nxt = w_tag;
            w_pause_nxt    = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
        w_pause_nxt = 1'b0;
      end
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_gba_cart_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_gba_cart_responder : scoreboard bench with a ROM responder model
// Revision 1.0 - initial release
// ============================================================================
module tb_gba_cart_responder;
  localparam int LIM = 300;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gba_cart_responder_if #(.ROM_ADDR_BITS(25)) bus ();

  gba_cart_responder #(
    .ROM_ADDR_BITS(25), .SRAM_ADDR_BITS(16), .PREFETCH_EN(1'b1)
  ) dut (
    .clock(clk), .reset(reset), .bus(bus.slave)
  );

  typedef struct { logic [31:0] data; logic chk_np; } exp_t;
  exp_t          sb[$];
  logic [24:0]   served[$];
  int            n_assert = 0;
  int            n_fail = 0;
  logic [7:0]    sram_mdl [0:65535];
  logic [31:0]   last_rdata = 32'd0;
  logic          rsp_en = 1'b1, lat_rand = 1'b0, stray_en = 1'b0;
  int            lat_fix = 5;
  logic          rsp_ack = 1'b0, man_ack = 1'b0;
  logic [31:0]   rsp_data = 32'd0, man_data = 32'd0;
  logic          stalled;
  logic [24:0]   saddr;

  assign bus.rom_ack   = rsp_ack | man_ack;
  assign bus.rom_rdata = man_ack ? man_data : rsp_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ROM contents: two fixed words, everything else a hash of the word address
  function automatic logic [31:0] rom_word(input logic [24:0] a);
    logic [31:0] x;
    x = {7'd0, a[24:2], 2'b00};
    if (x == 32'h100) return 32'hDEADBEEF;
    if (x == 32'h104) return 32'h11223344;
    return (x * 32'h9E3779B1) ^ 32'hA5C30F1E;
  endfunction

  function automatic logic is_rom(input logic [31:0] a);
    return (a[31:24] >= 8'h08) && (a[31:24] <= 8'h0D);
  endfunction

  function automatic logic is_sram(input logic [31:0] a);
    return (a[31:24] == 8'h0E) || (a[31:24] == 8'h0F);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_unpaused();
    int n = 0;
    while (bus.cpu_pause && n < LIM) begin tick(); n++; end
    if (n >= LIM) chk("pause_stuck", {31'd0, bus.cpu_pause}, 32'd0);
  endtask

  task automatic wait_req_low();
    int n = 0;
    while (bus.rom_req && n < LIM) begin tick(); n++; end
    chk("req_idle", {31'd0, bus.rom_req}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic st, output logic [24:0] sa);
    exp_t e;
    int   n = 0;
    tick();
    wait_unpaused();
    if (is_rom(addr))       e.data = rom_word(addr[24:0]);
    else if (is_sram(addr)) e.data = {4{sram_mdl[addr[15:0]]}};
    else                    e.data = last_rdata;
    e.chk_np = !is_rom(addr);
    last_rdata = e.data;
    sb.push_back(e);
    bus.cart_addr = addr; bus.cart_rd = 1'b1;
    tick();
    bus.cart_rd = 1'b0;
    st = bus.cpu_pause;
    sa = bus.rom_addr;
    // Stray strobes during a stall must be dropped by the responder.
    while (bus.cpu_pause && n < LIM) begin
      if (stray_en && $urandom_range(0, 3) == 0) begin
        bus.cart_addr = {7'h04, 2'b00, 23'($urandom), 2'b00};
        bus.cart_rd = 1'b1;
      end
      tick();
      bus.cart_rd = 1'b0;
      n++;
    end
    if (n >= LIM) chk("read_stall_timeout", {31'd0, bus.cpu_pause}, 32'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] d, input logic with_rd);
    tick();
    wait_unpaused();
    if (is_sram(addr)) sram_mdl[addr[15:0]] = d[7:0];
    bus.cart_addr = addr; bus.cart_wdata = d;
    bus.cart_wr = 1'b1; bus.cart_rd = with_rd;
    tick();
    bus.cart_wr = 1'b0; bus.cart_rd = 1'b0;
  endtask

  // External ROM: variable latency, also checks request stability until ack
  initial begin
    logic [24:0] a;
    int          lat;
    logic        ok;
    forever begin
      @(negedge clk);
      if (rsp_en && bus.rom_req && !reset) begin
        a = bus.rom_addr;
        lat = lat_rand ? $urandom_range(1, 6) : lat_fix;
        ok = 1'b1;
        repeat (lat - 1) begin
          @(negedge clk);
          if (!bus.rom_req || bus.rom_addr != a) ok = 1'b0;
        end
        chk("rom_req_hold", {31'd0, ok}, 32'd1);
        rsp_ack = 1'b1; rsp_data = rom_word(a);
        served.push_back(a);
        @(posedge clk); #1;
        rsp_ack = 1'b0; rsp_data = $urandom;
      end
    end
  end

  // Monitor: each accepted read yields data once the stall (if any) clears
  initial begin
    exp_t e;
    int   n;
    forever begin
      @(negedge clk);
      if (reset) sb.delete();
      else if (bus.cart_rd && !bus.cart_wr && !bus.cpu_pause) begin
        if (sb.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          n = 0;
          @(negedge clk);
          if (e.chk_np) chk("no_pause", {31'd0, bus.cpu_pause}, 32'd0);
          while (bus.cpu_pause && !reset && n < LIM) begin @(negedge clk); n++; end
          if (n >= LIM) chk("mon_timeout", {31'd0, bus.cpu_pause}, 32'd0);
          else if (!reset) chk("rdata", bus.cart_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          op;
    bus.cart_addr = 32'd0; bus.cart_rd = 1'b0; bus.cart_wr = 1'b0; bus.cart_wdata = 32'd0;
    repeat (3) tick();
    chk("reset_rdata", bus.cart_rdata, 32'd0);
    chk("reset_pause", {31'd0, bus.cpu_pause}, 32'd0);
    chk("reset_req",   {31'd0, bus.rom_req}, 32'd0);
    chk("reset_addr",  {7'd0, bus.rom_addr}, 32'd0);
    reset = 1'b0;

    // Demand miss, then prefetch of the next word
    do_read(32'h08000100, stalled, saddr);
    chk("t1_stalled", {31'd0, stalled}, 32'd1);
    chk("t1_fetch_addr", {7'd0, saddr}, 32'h100);
    chk("t1_pf_addr", {7'd0, bus.rom_addr}, 32'h104);
    chk("t1_pf_req", {31'd0, bus.rom_req}, 32'd1);

    // Prefetch hit starts the next prefetch
    wait_req_low();
    lat_fix = 20;
    do_read(32'h08000104, stalled, saddr);
    chk("t2_stalled", {31'd0, stalled}, 32'd0);
    chk("t2_pf_addr", {7'd0, bus.rom_addr}, 32'h108);
    chk("t2_pf_req", {31'd0, bus.rom_req}, 32'd1);

    // SRAM through a mirror, with a prefetch still in flight
    do_write(32'h0E000005, 32'h000000A5, 1'b0);
    do_read(32'h0E010005, stalled, saddr);
    chk("t3_stalled", {31'd0, stalled}, 32'd0);
    chk("t3_req", {31'd0, bus.rom_req}, 32'd1);

    // Miss during an in-flight prefetch
    do_read(32'h08400000, stalled, saddr);
    chk("t4_stalled", {31'd0, stalled}, 32'd1);
    chk("t4_served_last", {7'd0, served[served.size()-1]}, 32'h400000);
    chk("t4_served_prev", {7'd0, served[served.size()-2]}, 32'h108);

    // Reset in the middle of a fetch, then a stray ack
    wait_req_low();
    lat_fix = 3;
    rsp_en = 1'b0;
    tick();
    sb.push_back('{data: 32'd0, chk_np: 1'b0});
    bus.cart_addr = 32'h08000800; bus.cart_rd = 1'b1;
    tick();
    bus.cart_rd = 1'b0;
    chk("t5_req_before", {31'd0, bus.rom_req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    last_rdata = 32'd0;
    chk("t5_req", {31'd0, bus.rom_req}, 32'd0);
    chk("t5_pause", {31'd0, bus.cpu_pause}, 32'd0);
    chk("t5_rdata", bus.cart_rdata, 32'd0);
    man_ack = 1'b1; man_data = 32'hBAD0BAD0;
    tick();
    man_ack = 1'b0;
    tick();
    chk("t5_ack_ignored_rdata", bus.cart_rdata, 32'd0);
    chk("t5_ack_ignored_req", {31'd0, bus.rom_req}, 32'd0);
    rsp_en = 1'b1;
    do_read(32'h08000800, stalled, saddr);
    chk("t5_reread_miss", {31'd0, stalled}, 32'd1);

    // Open bus on an unmapped read
    wait_req_low();
    do_read(32'h08000100, stalled, saddr);
    wait_req_low();
    do_read(32'h02000000, stalled, saddr);
    chk("t6_stalled", {31'd0, stalled}, 32'd0);
    chk("t6_req", {31'd0, bus.rom_req}, 32'd0);

    // Last ROM word: prefetch wraps to word 0
    do_read(32'h09FFFFFC, stalled, saddr);
    chk("wrap_stalled", {31'd0, stalled}, 32'd1);
    chk("wrap_pf_addr", {7'd0, bus.rom_addr}, 32'd0);

    // Random mix
    for (int i = 0; i < 16; i++) do_write(32'h0E000000 | i, $urandom, 1'b0);
    lat_rand = 1'b1;
    stray_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        a = {7'($urandom_range(4, 6)), 23'($urandom_range(0, 23) + 32'h40), 2'($urandom)};
        if ($urandom_range(0, 9) == 0) a[24:2] = 23'h7FFFFF - 23'($urandom_range(0, 1));
        do_read(a, stalled, saddr);
      end else if (op <= 7 || op == 9) begin
        a = {7'h07, 1'($urandom), 8'($urandom), 16'($urandom_range(0, 15))};
        if (op <= 6) do_read(a, stalled, saddr);
        else do_write(a, $urandom, op == 9);
      end else begin
        a = $urandom;
        if (a[31:24] inside {[8'h08:8'h0F]}) a[31:24] = 8'h03;
        do_read(a, stalled, saddr);
      end
    end
    repeat (20) tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
